// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter sharing one bank of WIDTH JK flops
// between NREQ clients. The granted client's {j,k} opcode is applied to the
// bank bits selected by its mask, and every grant bumps op_count.
// Optional feature: define ARB_LOCK_EN to let a granted client hold the
// arbiter through req_lock.
//
// Lock state (ARB_LOCK_EN only):
//   state      | meaning
//   lock_vld=0 | free round-robin, scan starts at ptr
//   lock_vld=1 | arbiter owned by lock_owner, only it may be granted
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_mask,
  input  logic [NREQ-1:0]       req_lock,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [CNTW-1:0]       op_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]    ptr, ptr_nxt;
  logic [NREQ-1:0]  rr_gnt, gnt_raw;
  logic [PW-1:0]    rr_idx, win_idx;
  logic             any_gnt;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_mask, q_nxt;

`ifdef ARB_LOCK_EN
  logic          lock_vld, lock_vld_nxt;
  logic [PW-1:0] lock_owner, lock_owner_nxt;
`else
  logic unused_req_lock;
  assign unused_req_lock = ^req_lock;
`endif

  // Round-robin scan from ptr upward with wrap; first requester wins.
  always_comb begin
    int idx;
    logic found;
    rr_gnt = '0;
    rr_idx = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        rr_gnt[idx] = 1'b1;
        rr_idx      = PW'(idx);
        found       = 1'b1;
      end
    end
  end

  // Output logic: raw grant (lock overrides round-robin), gated by reset.
  always_comb begin
`ifdef ARB_LOCK_EN
    if (lock_vld) begin
      gnt_raw             = '0;
      gnt_raw[lock_owner] = req[lock_owner];
      win_idx             = lock_owner;
    end else begin
      gnt_raw = rr_gnt;
      win_idx = rr_idx;
    end
`else
    gnt_raw = rr_gnt;
    win_idx = rr_idx;
`endif
    any_gnt = |gnt_raw;
    gnt     = rstn ? gnt_raw : '0;
  end

  // Next-state logic for the pointer and, when enabled, the lock.
  always_comb begin
    ptr_nxt = ptr;
`ifdef ARB_LOCK_EN
    lock_vld_nxt   = lock_vld;
    lock_owner_nxt = lock_owner;
    if (lock_vld) begin
      // Release on the first edge where the owner drops req or req_lock;
      // a still-requesting owner gets its final op applied on that edge.
      if (!req[lock_owner] || !req_lock[lock_owner]) begin
        lock_vld_nxt = 1'b0;
        ptr_nxt      = PW'((int'(lock_owner) + 1) % NREQ);
      end
    end else if (any_gnt) begin
      if (req_lock[win_idx]) begin
        lock_vld_nxt   = 1'b1;
        lock_owner_nxt = win_idx;
      end else begin
        ptr_nxt = PW'((int'(win_idx) + 1) % NREQ);
      end
    end
`else
    if (any_gnt) ptr_nxt = PW'((int'(win_idx) + 1) % NREQ);
`endif
  end

  // Select the winner's opcode and mask; non-granted clients never reach the bank.
  always_comb begin
    sel_op   = 2'b00;
    sel_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_raw[i]) begin
        sel_op   = req_op[2*i +: 2];
        sel_mask = req_mask[WIDTH*i +: WIDTH];
      end
    end
  end

  // JK update per masked bank bit: 00 hold, 01 clear, 10 set, 11 toggle.
  always_comb begin
    q_nxt = q;
    for (int b = 0; b < WIDTH; b++) begin
      if (sel_mask[b]) begin
        case (sel_op)
          2'b01:   q_nxt[b] = 1'b0;
          2'b10:   q_nxt[b] = 1'b1;
          2'b11:   q_nxt[b] = ~q[b];
          default: q_nxt[b] = q[b];
        endcase
      end
    end
  end

  // State register: bank, pointer, counter and lock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q        <= '0;
      ptr      <= '0;
      op_count <= '0;
`ifdef ARB_LOCK_EN
      lock_vld   <= 1'b0;
      lock_owner <= '0;
`endif
    end else begin
      q   <= q_nxt;
      ptr <= ptr_nxt;
      if (any_gnt) op_count <= op_count + 1'b1;
`ifdef ARB_LOCK_EN
      lock_vld   <= lock_vld_nxt;
      lock_owner <= lock_owner_nxt;
`endif
    end
  end

endmodule
